// File: rtl/inst_fetch_if.sv
// Instruction fetch interface: issues one word fetch at a time on the instruction bus.
// The fetched word is delivered to IF/ID with stall buffering, flush draining and misaligned-pc faults.
module inst_fetch_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pc,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        stallreq,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        inst_misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] inst_reg, inst_next;
  logic        valid_reg, valid_next;
  logic        misalign_reg, misalign_next;
  logic [31:0] hold_reg, hold_next;

  logic stall_id;
  logic pc_misaligned;
  logic unused_stall_bits;

  assign stall_id          = stall[1];
  assign pc_misaligned     = |pc[1:0];
  assign unused_stall_bits = ^{stall[5:2], stall[0]};

  assign mem_req       = (state_reg == BUSY) || (state_reg == DRAIN);
  assign mem_addr      = addr_reg;
  assign inst          = inst_reg;
  assign inst_valid    = valid_reg;
  assign inst_misalign = misalign_reg;

  // PC may advance once the bus acknowledges, or when a misaligned pc is faulted immediately.
  assign stallreq = ce & ~(((state_reg == BUSY) & mem_ack) |
                           ((state_reg == IDLE) & pc_misaligned & ~stall_id));

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    hold_next     = hold_reg;
    inst_next     = 32'd0;
    valid_next    = 1'b0;
    misalign_next = 1'b0;

    if (flush) begin
      hold_next = 32'd0;
      case (state_reg)
        BUSY, DRAIN: state_next = mem_ack ? IDLE : DRAIN;
        default:     state_next = IDLE;
      endcase
    end else if (stall_id) begin
      // IF/ID is frozen: keep the delivered slot, park any returning word in the hold buffer.
      inst_next     = inst_reg;
      valid_next    = valid_reg;
      misalign_next = misalign_reg;
      case (state_reg)
        BUSY: begin
          if (mem_ack) begin
            hold_next  = mem_rdata;
            state_next = HOLD;
          end
        end
        DRAIN: begin
          if (mem_ack) state_next = IDLE;
        end
        default: ;
      endcase
    end else begin
      case (state_reg)
        IDLE: begin
          if (ce) begin
            if (pc_misaligned) begin
              valid_next    = 1'b1;
              misalign_next = 1'b1;
            end else begin
              addr_next  = pc;
              state_next = BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            inst_next  = mem_rdata;
            valid_next = 1'b1;
            state_next = IDLE;
          end
        end
        DRAIN: begin
          if (mem_ack) state_next = IDLE;
        end
        HOLD: begin
          inst_next  = hold_reg;
          valid_next = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= 32'd0;
      inst_reg     <= 32'd0;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      hold_reg     <= 32'd0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      inst_reg     <= inst_next;
      valid_reg    <= valid_next;
      misalign_reg <= misalign_next;
      hold_reg     <= hold_next;
    end
  end

endmodule

// File: tb/tb_inst_fetch_if.sv
// Directed bench for inst_fetch_if: one table row per clock cycle, plus hand-written
// sequences for asynchronous reset in the middle of a fetch.
module tb_inst_fetch_if;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic [5:0]  stall;
  logic        flush;
  logic        stallreq;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_misalign;

  int vectors;
  int miscompares;

  inst_fetch_if dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .pc           (pc),
    .stall        (stall),
    .flush        (flush),
    .stallreq     (stallreq),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .inst_misalign(inst_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic [5:0]  stall;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic        e_stallreq;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic c, input logic [31:0] p, input logic [5:0] s,
                     input logic f, input logic a, input logic [31:0] d,
                     input logic esr, input logic ereq, input logic [31:0] eaddr,
                     input logic [31:0] einst, input logic ev, input logic em);
    vec_t v;
    v.rst = r; v.ce = c; v.pc = p; v.stall = s; v.flush = f; v.ack = a; v.rdata = d;
    v.e_stallreq = esr; v.e_req = ereq; v.e_addr = eaddr;
    v.e_inst = einst; v.e_valid = ev; v.e_mis = em;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic esr, input logic ereq,
                       input logic [31:0] eaddr, input logic [31:0] einst,
                       input logic ev, input logic em);
    vectors++;
    if (stallreq !== esr || mem_req !== ereq || mem_addr !== eaddr ||
        inst !== einst || inst_valid !== ev || inst_misalign !== em) begin
      miscompares++;
      $display("FAIL %s: got stallreq=%b mem_req=%b mem_addr=%h inst=%h valid=%b mis=%b, want stallreq=%b mem_req=%b mem_addr=%h inst=%h valid=%b mis=%b",
               name, stallreq, mem_req, mem_addr, inst, inst_valid, inst_misalign,
               esr, ereq, eaddr, einst, ev, em);
    end else begin
      $display("ok   %s: stallreq=%b mem_req=%b mem_addr=%h inst=%h valid=%b mis=%b",
               name, stallreq, mem_req, mem_addr, inst, inst_valid, inst_misalign);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; ce = 1'b0; pc = 32'd0; stall = 6'd0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'd0;

    //   rst ce pc        stall  fl ack rdata          | sreq req addr      inst        v  m
    add(1, 0, 32'h000, 6'd0, 0, 0, 32'h0,        0, 0, 32'h000, 32'h0,        0, 0); // reset
    add(0, 1, 32'h100, 6'd0, 0, 0, 32'h0,        1, 0, 32'h000, 32'h0,        0, 0); // zero-wait fetch
    add(0, 1, 32'h100, 6'd0, 0, 1, 32'h3C011234, 0, 1, 32'h100, 32'h0,        0, 0);
    add(0, 0, 32'h104, 6'd0, 0, 0, 32'h0,        0, 0, 32'h100, 32'h3C011234, 1, 0);
    add(0, 1, 32'h104, 6'd0, 0, 0, 32'h0,        1, 0, 32'h100, 32'h0,        0, 0); // 3 wait states
    add(0, 1, 32'h104, 6'd0, 0, 0, 32'h0,        1, 1, 32'h104, 32'h0,        0, 0);
    add(0, 1, 32'h104, 6'd0, 0, 0, 32'h0,        1, 1, 32'h104, 32'h0,        0, 0);
    add(0, 1, 32'h104, 6'd0, 0, 0, 32'h0,        1, 1, 32'h104, 32'h0,        0, 0);
    add(0, 1, 32'h104, 6'd0, 0, 1, 32'hAAAA0001, 0, 1, 32'h104, 32'h0,        0, 0);
    add(0, 1, 32'h108, 6'd0, 0, 0, 32'h0,        1, 0, 32'h104, 32'hAAAA0001, 1, 0); // ack under stall
    add(0, 1, 32'h108, 6'd3, 0, 1, 32'hBBBB0002, 0, 1, 32'h108, 32'h0,        0, 0);
    add(0, 1, 32'h108, 6'd3, 0, 0, 32'h0,        1, 0, 32'h108, 32'h0,        0, 0);
    add(0, 1, 32'h108, 6'd0, 0, 0, 32'h0,        1, 0, 32'h108, 32'h0,        0, 0);
    add(0, 0, 32'h10C, 6'd0, 0, 0, 32'h0,        0, 0, 32'h108, 32'hBBBB0002, 1, 0);
    add(0, 1, 32'h10C, 6'd0, 0, 0, 32'h0,        1, 0, 32'h108, 32'h0,        0, 0); // flush in BUSY
    add(0, 1, 32'h10C, 6'd0, 1, 0, 32'h0,        1, 1, 32'h10C, 32'h0,        0, 0);
    add(0, 1, 32'h10C, 6'd0, 0, 0, 32'h0,        1, 1, 32'h10C, 32'h0,        0, 0);
    add(0, 1, 32'h10C, 6'd0, 0, 1, 32'h0000DEAD, 1, 1, 32'h10C, 32'h0,        0, 0);
    add(0, 0, 32'h10C, 6'd0, 0, 0, 32'h0,        0, 0, 32'h10C, 32'h0,        0, 0);
    add(0, 1, 32'h102, 6'd0, 0, 0, 32'h0,        0, 0, 32'h10C, 32'h0,        0, 0); // misaligned pc
    add(0, 0, 32'h102, 6'd0, 0, 0, 32'h0,        0, 0, 32'h10C, 32'h0,        1, 1);
    add(0, 0, 32'h102, 6'd0, 0, 0, 32'h0,        0, 0, 32'h10C, 32'h0,        0, 0);
    add(0, 1, 32'h106, 6'd0, 0, 0, 32'h0,        0, 0, 32'h10C, 32'h0,        0, 0); // fault held by stall
    add(0, 1, 32'h106, 6'd3, 0, 0, 32'h0,        1, 0, 32'h10C, 32'h0,        1, 1);
    add(0, 0, 32'h106, 6'd0, 0, 0, 32'h0,        0, 0, 32'h10C, 32'h0,        1, 1);
    add(0, 0, 32'h106, 6'd0, 0, 0, 32'h0,        0, 0, 32'h10C, 32'h0,        0, 0);
    add(0, 0, 32'h106, 6'd0, 0, 1, 32'h12345678, 0, 0, 32'h10C, 32'h0,        0, 0); // ack in IDLE
    add(0, 0, 32'h106, 6'd0, 0, 0, 32'h0,        0, 0, 32'h10C, 32'h0,        0, 0);
    add(0, 1, 32'h110, 6'd0, 0, 0, 32'h0,        1, 0, 32'h10C, 32'h0,        0, 0); // flush in HOLD
    add(0, 1, 32'h110, 6'd3, 0, 1, 32'hCCCC0003, 0, 1, 32'h110, 32'h0,        0, 0);
    add(0, 1, 32'h110, 6'd3, 1, 0, 32'h0,        1, 0, 32'h110, 32'h0,        0, 0);
    add(0, 0, 32'h110, 6'd0, 0, 0, 32'h0,        0, 0, 32'h110, 32'h0,        0, 0);
    add(0, 0, 32'h110, 6'd0, 0, 0, 32'h0,        0, 0, 32'h110, 32'h0,        0, 0);
    add(0, 1, 32'h114, 6'd0, 0, 0, 32'h0,        1, 0, 32'h110, 32'h0,        0, 0); // flush with ack
    add(0, 1, 32'h114, 6'd0, 1, 1, 32'h0000EEEE, 0, 1, 32'h114, 32'h0,        0, 0);
    add(0, 0, 32'h114, 6'd0, 0, 0, 32'h0,        0, 0, 32'h114, 32'h0,        0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; ce = vecs[i].ce; pc = vecs[i].pc; stall = vecs[i].stall;
      flush = vecs[i].flush; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
      #3;
      check($sformatf("row%0d", i), vecs[i].e_stallreq, vecs[i].e_req, vecs[i].e_addr,
            vecs[i].e_inst, vecs[i].e_valid, vecs[i].e_mis);
    end

    // Reset asserted between edges while a fetch is outstanding, then a stray ack.
    @(posedge clk); #1;
    ce = 1'b1; pc = 32'h118; stall = 6'd0; flush = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    check("busy_before_rst", 1'b1, 1'b1, 32'h118, 32'h0, 1'b0, 1'b0);
    #1; rst = 1'b1; ce = 1'b0;
    #1;
    check("async_rst_busy", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #3;
    check("stray_ack_cycle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #3;
    check("after_stray_ack", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset asserted while a delivered instruction is on the IF/ID outputs.
    @(posedge clk); #1;
    ce = 1'b1; pc = 32'h120;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    #3;
    check("fetch_120_ack", 1'b0, 1'b1, 32'h120, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0; ce = 1'b0;
    #1;
    check("deliver_120", 1'b0, 1'b0, 32'h120, 32'h55AA55AA, 1'b1, 1'b0);
    #1; rst = 1'b1;
    #1;
    check("async_rst_inst", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
